// File: rtl/core_sequencer.sv
// Fetch/decode/execute sequencer that owns the PC and instruction register.
// Define SEQ_SINGLE_STEP_EN so that every retire parks in IDLE (one instruction per start).
module core_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               dec_reg_we,
  input  logic               dec_mem_we,
  input  logic               dec_illegal,
  output logic               reg_we,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               retired,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_STORE  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halt_pend_q, halt_pend_d;
  logic               stop_at_retire;

  assign busy      = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault     = (state_q == S_FAULT);
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;

`ifdef SEQ_SINGLE_STEP_EN
  assign stop_at_retire = 1'b1;
`else
  // A halt raised in the retire cycle itself still stops this retire.
  assign stop_at_retire = halt_pend_q | halt_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= {INSTR_W{1'b0}};
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    reg_we   = 1'b0;
    dmem_req = 1'b0;
    retired  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_illegal) state_d = S_FAULT;
        else             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem_we) begin
          state_d = S_STORE;
        end else begin
          reg_we  = dec_reg_we;
          retired = 1'b1;
          state_d = stop_at_retire ? S_IDLE : S_FETCH;
        end
      end
      S_STORE: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          retired = 1'b1;
          state_d = stop_at_retire ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_STORE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    // Entering IDLE consumes any pending halt.
    halt_pend_d = (state_d == S_IDLE) ? 1'b0 : (halt_pend_q | (busy & halt_req));
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench: builds a cycle timeline per episode from instruction-level rules and compares every cycle.
module tb_core_sequencer;
  localparam int unsigned PC_W = 8;
  localparam int unsigned INSTR_W = 8;
  localparam logic [7:0] RPC = 8'hFC;
  localparam int NC = 400;
  localparam int AN = NC + 64;
  localparam int NEP = 4;
`ifdef SEQ_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic clk, rst_n, start, halt_req, imem_req, imem_ack, dec_reg_we, dec_mem_we, dec_illegal;
  logic reg_we, dmem_req, dmem_ack, busy, retired, fault;
  logic [PC_W-1:0] imem_addr, pc;
  logic [INSTR_W-1:0] imem_rdata, ir;

  core_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we), .dec_illegal(dec_illegal),
    .reg_we(reg_we), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc(pc),
    .busy(busy), .retired(retired), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic e_req[AN], e_rwe[AN], e_dreq[AN], e_ret[AN], e_busy[AN], e_flt[AN];
  logic [7:0] e_pc[AN], e_ir[AN];
  logic a_start[AN], a_halt[AN], a_iack[AN], a_dack[AN];
  logic [7:0] mem[256];
  int total, bad, t;
  logic [7:0] m_pc, m_ir;
  logic hp;

  function automatic logic is_ill(input logic [7:0] x);
    return x == 8'hFF;
  endfunction
  function automatic logic is_st(input logic [7:0] x);
    return x[7:6] == 2'b10;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp, input int cyc);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One expected cycle; environment inputs get random defaults that the design must ignore.
  task automatic emit(input logic req, input logic rwe, input logic dreq, input logic ret,
                      input logic bsy, input logic flt);
    e_req[t] = req; e_rwe[t] = rwe; e_dreq[t] = dreq; e_ret[t] = ret;
    e_busy[t] = bsy; e_flt[t] = flt; e_pc[t] = m_pc; e_ir[t] = m_ir;
    a_start[t] = (bsy || flt) ? ($urandom % 5 == 0) : 1'b0;
    a_halt[t] = bsy ? ($urandom % 16 == 0) : ($urandom % 8 == 0);
    a_iack[t] = ($urandom % 4 == 0);
    a_dack[t] = ($urandom % 4 == 0);
    if (bsy && a_halt[t]) hp = 1'b1;
    t++;
  endtask

  task automatic build(input int ep);
    int w, d, l;
    logic done, stop;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hFF) mem[i] = 8'hFE;
    end
    if (ep == NEP - 1) mem[RPC + 8'd3] = 8'hFF;
    t = 0; m_pc = RPC; m_ir = 8'h00; hp = 1'b0; done = 1'b0;
    while (t < NC && !done) begin
      l = $urandom_range(0, 3);
      for (int i = 0; i < l; i++) emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      a_start[t-1] = 1'b1;
      hp = 1'b0; stop = 1'b0;
      while (!stop && t < NC) begin
        w = ($urandom % 8 == 0) ? 5 : $urandom_range(0, 1);
        for (int i = 0; i <= w; i++) begin
          emit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          a_iack[t-1] = (i == w);
        end
        m_ir = mem[m_pc];
        m_pc = m_pc + 8'd1;
        emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (is_ill(m_ir)) begin
          while (t < NC) emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          done = 1'b1; stop = 1'b1;
        end else if (is_st(m_ir)) begin
          emit(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          d = $urandom_range(0, 3);
          for (int i = 0; i <= d; i++) begin
            emit(1'b0, 1'b0, 1'b1, (i == d), 1'b1, 1'b0);
            a_dack[t-1] = (i == d);
          end
        end else begin
          emit(1'b0, m_ir[0], 1'b0, 1'b1, 1'b1, 1'b0);
        end
        if (!done && (hp || SS)) stop = 1'b1;
      end
    end
  endtask

  task automatic check_reset(input int cyc);
    check("rst_req", 8'(imem_req), 8'h00, cyc);
    check("rst_busy", 8'(busy), 8'h00, cyc);
    check("rst_pc", pc, RPC, cyc);
    check("rst_ir", ir, 8'h00, cyc);
    check("rst_fault", 8'(fault), 8'h00, cyc);
    check("rst_ret", 8'(retired), 8'h00, cyc);
    check("rst_regwe", 8'(reg_we), 8'h00, cyc);
    check("rst_dreq", 8'(dmem_req), 8'h00, cyc);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 8'h00; dec_reg_we = 1'b0; dec_mem_we = 1'b0; dec_illegal = 1'b0;
    @(negedge clk);
    #1 check_reset(-1);
    for (int ep = 0; ep < NEP; ep++) begin
      build(ep);
      for (int c = 0; c < NC; c++) begin
        @(negedge clk);
        rst_n = 1'b1;
        start = a_start[c];
        halt_req = a_halt[c];
        imem_ack = a_iack[c];
        dmem_ack = a_dack[c];
        imem_rdata = e_req[c] ? mem[e_pc[c]] : 8'($urandom);
        dec_illegal = is_ill(e_ir[c]);
        dec_mem_we = is_st(e_ir[c]);
        dec_reg_we = e_ir[c][0];
        #1;
        check("imem_req", 8'(imem_req), 8'(e_req[c]), c);
        check("imem_addr", imem_addr, e_pc[c], c);
        check("pc", pc, e_pc[c], c);
        check("ir", ir, e_ir[c], c);
        check("reg_we", 8'(reg_we), 8'(e_rwe[c]), c);
        check("dmem_req", 8'(dmem_req), 8'(e_dreq[c]), c);
        check("retired", 8'(retired), 8'(e_ret[c]), c);
        check("busy", 8'(busy), 8'(e_busy[c]), c);
        check("fault", 8'(fault), 8'(e_flt[c]), c);
      end
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset(NC);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
